// File: rtl/pc_sequencer.sv
// Program counter sequencer: chooses the next PC, raises instruction/data memory
// requests, latches halt and counts retired instructions and memory stall cycles.
module pc_sequencer #(
  parameter int unsigned         PC_W     = 32,
  parameter logic [PC_W-1:0]     RESET_PC = '0,
  parameter int unsigned         CNT_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dREN_in,
  input  logic              dWEN_in,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  input  logic              jmp,
  input  logic [PC_W-1:0]   jmp_target,
  input  logic              halt_in,
  output logic [PC_W-1:0]   pc_next,
  output logic              pcWEN,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic              halt,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DATA  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_npc;
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stall;

  logic [PC_W-1:0]  w_tgt_raw;
  logic [PC_W-1:0]  w_tgt;
  logic             w_npc_ld;
  logic             w_ret_inc;
  logic             w_stall_inc;

  // Jump outranks a taken branch; targets are always word aligned.
  assign w_tgt_raw = jmp      ? jmp_target :
                     br_taken ? br_target  :
                                pc_in + PC_W'(4);
  assign w_tgt     = {w_tgt_raw[PC_W-1:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    pc_next     = pc_in;
    pcWEN       = 1'b0;
    imemREN     = 1'b0;
    dmemREN     = 1'b0;
    dmemWEN     = 1'b0;
    w_npc_ld    = 1'b0;
    w_ret_inc   = 1'b0;
    w_stall_inc = 1'b0;
    case (r_state)
      S_FETCH: begin
        imemREN = 1'b1;
        if (!ihit) begin
          w_stall_inc = 1'b1;
        end else if (halt_in) begin
          w_state_nxt = S_HALT;
          w_ret_inc   = 1'b1;
        end else if (dREN_in || dWEN_in) begin
          w_npc_ld    = 1'b1;
          w_state_nxt = S_DATA;
        end else begin
          pcWEN     = 1'b1;
          pc_next   = w_tgt;
          w_ret_inc = 1'b1;
        end
      end
      S_DATA: begin
        dmemREN = dREN_in;
        dmemWEN = dWEN_in;
        if (dhit) begin
          pcWEN       = 1'b1;
          pc_next     = r_npc;
          w_ret_inc   = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_stall_inc = 1'b1;
        end
      end
      default: ;
    endcase
    // Reset must drop requests in the same cycle, not only after the state clears.
    if (RST) begin
      pc_next = RESET_PC;
      pcWEN   = 1'b0;
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_npc     <= RESET_PC;
      r_retired <= '0;
      r_stall   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_npc_ld) r_npc <= w_tgt;
      if (w_ret_inc && (r_retired != '1)) r_retired <= r_retired + CNT_W'(1);
      if (w_stall_inc && (r_stall != '1)) r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign halt        = (r_state == S_HALT);
  assign retired_cnt = r_retired;
  assign stall_cnt   = r_stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] pc_in;
  logic        ihit, dhit, dREN_in, dWEN_in, br_taken, jmp, halt_in;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc_next;
  logic        pcWEN, imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] retired_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] pcn;
    logic        wen, im, dr, dw, h;
    logic [31:0] ret, st;
  } exp_t;

  exp_t q[$];

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .PC_W     (32),
    .RESET_PC (32'h0000_0080),
    .CNT_W    (32)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .pc_in       (pc_in),
    .ihit        (ihit),
    .dhit        (dhit),
    .dREN_in     (dREN_in),
    .dWEN_in     (dWEN_in),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .halt_in     (halt_in),
    .pc_next     (pc_next),
    .pcWEN       (pcWEN),
    .imemREN     (imemREN),
    .dmemREN     (dmemREN),
    .dmemWEN     (dmemWEN),
    .halt        (halt),
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
  );

  task automatic chk(input int id, input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.id, "pc_next",     pc_next,            e.pcn);
      chk(e.id, "pcWEN",       {31'd0, pcWEN},     {31'd0, e.wen});
      chk(e.id, "imemREN",     {31'd0, imemREN},   {31'd0, e.im});
      chk(e.id, "dmemREN",     {31'd0, dmemREN},   {31'd0, e.dr});
      chk(e.id, "dmemWEN",     {31'd0, dmemWEN},   {31'd0, e.dw});
      chk(e.id, "halt",        {31'd0, halt},      {31'd0, e.h});
      chk(e.id, "retired_cnt", retired_cnt,        e.ret);
      chk(e.id, "stall_cnt",   stall_cnt,          e.st);
    end
  end

  int vid = 0;

  // Push the expectation for the inputs currently applied, then advance one cycle.
  task automatic step(input logic [31:0] pcn, input logic wen, input logic im,
                      input logic dr, input logic dw, input logic h,
                      input logic [31:0] ret, input logic [31:0] st);
    exp_t e;
    e.id = vid; e.pcn = pcn; e.wen = wen; e.im = im; e.dr = dr; e.dw = dw;
    e.h = h; e.ret = ret; e.st = st;
    q.push_back(e);
    vid++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; dREN_in = 0; dWEN_in = 0; br_taken = 0; jmp = 0; halt_in = 0;
    br_target = '0; jmp_target = '0;
  endtask

  initial begin
    RST = 1'b1;
    pc_in = 32'h100;
    idle_inputs();
    @(posedge CLK); #1;

    // reset: RESET_PC presented, no enables
    step(32'h80, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;

    // sequential fetch
    ihit = 1; pc_in = 32'h100; step(32'h104, 1, 1, 0, 0, 0, 0, 0);
    pc_in = 32'h104;           step(32'h108, 1, 1, 0, 0, 0, 1, 0);
    pc_in = 32'h108;           step(32'h10C, 1, 1, 0, 0, 0, 2, 0);
    // fetch miss
    ihit = 0; pc_in = 32'h10C; step(32'h10C, 0, 1, 0, 0, 0, 3, 0);
    // jump beats branch, low bits cleared
    ihit = 1; br_taken = 1; br_target = 32'h200; jmp = 1; jmp_target = 32'h303;
    step(32'h300, 1, 1, 0, 0, 0, 3, 1);
    jmp = 0; br_target = 32'h207;
    step(32'h204, 1, 1, 0, 0, 0, 4, 1);
    // wrap
    br_taken = 0; pc_in = 32'hFFFF_FFFC;
    step(32'h0, 1, 1, 0, 0, 0, 5, 1);

    // load with two wait cycles; redirect changes during DATA are ignored
    pc_in = 32'h40; dREN_in = 1;
    step(32'h40, 0, 1, 0, 0, 0, 6, 1);
    ihit = 0; br_taken = 1; br_target = 32'h500;
    step(32'h40, 0, 0, 1, 0, 0, 6, 1);
    step(32'h40, 0, 0, 1, 0, 0, 6, 2);
    dhit = 1;
    step(32'h44, 1, 0, 1, 0, 0, 6, 3);

    // store; ihit in DATA ignored; both data enables forwarded
    idle_inputs(); pc_in = 32'h44; ihit = 1; dWEN_in = 1;
    step(32'h44, 0, 1, 0, 0, 0, 7, 3);
    dREN_in = 1;
    step(32'h44, 0, 0, 1, 1, 0, 7, 3);
    dREN_in = 0; ihit = 0; dhit = 1;
    step(32'h48, 1, 0, 0, 1, 0, 7, 4);

    // dhit ignored in FETCH
    idle_inputs(); pc_in = 32'h48; dhit = 1;
    step(32'h48, 0, 1, 0, 0, 0, 8, 4);

    // reset mid-DATA
    idle_inputs(); ihit = 1; dREN_in = 1;
    step(32'h48, 0, 1, 0, 0, 0, 8, 5);
    ihit = 0;
    step(32'h48, 0, 0, 1, 0, 0, 8, 5);
    RST = 1'b1;
    step(32'h80, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    step(32'h48, 0, 1, 0, 0, 0, 0, 0);

    // halt, then everything ignored until reset
    idle_inputs(); ihit = 1; halt_in = 1;
    step(32'h48, 0, 1, 0, 0, 0, 0, 1);
    halt_in = 0; dhit = 1; dREN_in = 1;
    for (int i = 0; i < 11; i++) step(32'h48, 0, 0, 0, 0, 1, 1, 1);
    RST = 1'b1;
    step(32'h80, 0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0; idle_inputs(); ihit = 1; pc_in = 32'h200;
    step(32'h204, 1, 1, 0, 0, 0, 0, 0);

    idle_inputs();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
